// File: rtl/bios_fetch_if.sv
// rtl/bios_fetch_if.sv - BIOS fetch port bundle: instruction memory, redirect, instruction output.
interface bios_fetch_if #(
  parameter int ADDR_W = 12
);
  logic              start;
  logic              imem_en;
  logic [ADDR_W-1:0] imem_addr;
  logic [31:0]       imem_rdata;
  logic              redirect_valid;
  logic [31:0]       redirect_pc;
  logic              inst_valid;
  logic              inst_ready;
  logic [31:0]       inst;
  logic [31:0]       inst_pc;
  logic              fault;

  modport master (
    input  start,
    input  imem_rdata,
    input  redirect_valid,
    input  redirect_pc,
    input  inst_ready,
    output imem_en,
    output imem_addr,
    output inst_valid,
    output inst,
    output inst_pc,
    output fault
  );

  modport slave (
    output start,
    output imem_rdata,
    output redirect_valid,
    output redirect_pc,
    output inst_ready,
    input  imem_en,
    input  imem_addr,
    input  inst_valid,
    input  inst,
    input  inst_pc,
    input  fault
  );
endinterface

// File: rtl/bios_fetch.sv
// rtl/bios_fetch.sv - BIOS instruction fetch unit with one-deep output register and redirect/fault handling.
module bios_fetch #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter int          ADDR_W   = 12
) (
  input logic          clk,
  input logic          rst_n,
  bios_fetch_if.master bus
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    RUN   = 2'd1,
    FAULT = 2'd2
  } state_t;

  state_t      state_q;
  state_t      state_d;
  logic [31:0] pc_q;
  logic        inst_valid_q;
  logic [31:0] inst_q;
  logic [31:0] inst_pc_q;
  logic        fault_q;

  logic        can_accept;
  logic        fetch;
  logic        redirect_misaligned;

  assign can_accept          = !inst_valid_q || bus.inst_ready;
  assign redirect_misaligned = bus.redirect_valid && (bus.redirect_pc[1:0] != 2'b00);
  // A redirect in flight suppresses the fetch so the stale pc is never read.
  assign fetch               = (state_q == RUN) && can_accept && !bus.redirect_valid;

  assign bus.imem_en    = fetch;
  assign bus.imem_addr  = pc_q[ADDR_W-1:0];
  assign bus.inst_valid = inst_valid_q;
  assign bus.inst       = inst_q;
  assign bus.inst_pc    = inst_pc_q;
  assign bus.fault      = fault_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE: begin
        if (redirect_misaligned) begin
          state_d = FAULT;
        end else if (bus.start) begin
          state_d = RUN;
        end
      end
      RUN: begin
        if (redirect_misaligned) begin
          state_d = FAULT;
        end
      end
      FAULT: begin
        if (bus.redirect_valid && !redirect_misaligned) begin
          state_d = RUN;
        end
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      fault_q      <= 1'b0;
      pc_q         <= RESET_PC;
      inst_valid_q <= 1'b0;
      inst_q       <= 32'h0;
      inst_pc_q    <= 32'h0;
    end else begin
      fault_q <= (state_d == FAULT);
      // Redirect wins over both fetch and stall; it also drops any held word.
      if (bus.redirect_valid) begin
        pc_q         <= bus.redirect_pc;
        inst_valid_q <= 1'b0;
      end else if (fetch) begin
        inst_q       <= bus.imem_rdata;
        inst_pc_q    <= pc_q;
        inst_valid_q <= 1'b1;
        pc_q         <= pc_q + 32'd4;
      end else if (can_accept) begin
        inst_valid_q <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_bios_fetch.sv
// tb/tb_bios_fetch.sv - randomized and directed check of bios_fetch against a behavioural model.
module tb_bios_fetch;

  logic clk;
  logic rst_n;
  int   n_vec = 0;
  int   n_err = 0;
  bit   cmp_en = 0;

  bios_fetch_if #(.ADDR_W(12)) bus ();

  bios_fetch #(.RESET_PC(32'h0000_0000), .ADDR_W(12)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] mem_word(input logic [11:0] a);
    return 32'h1000_0000 + {22'h0, a[11:2]};
  endfunction

  assign bus.imem_rdata = mem_word(bus.imem_addr);

  // Model: phase 0 = idle, 1 = running, 2 = faulted.
  int          m_ph    = 0;
  logic [31:0] m_pc    = 32'h0;
  bit          m_valid = 0;
  logic [31:0] m_inst  = 32'h0;
  logic [31:0] m_ipc   = 32'h0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_ph = 0; m_pc = 32'h0; m_valid = 0; m_inst = 32'h0; m_ipc = 32'h0;
    end else begin
      bit accept, take, rv;
      rv     = bus.redirect_valid;
      accept = !m_valid || bus.inst_ready;
      take   = (m_ph == 1) && accept && !rv;
      if (rv && bus.redirect_pc[1:0] != 2'b00) m_ph = 2;
      else if (rv && m_ph == 2)                m_ph = 1;
      else if (m_ph == 0 && bus.start)         m_ph = 1;
      if (rv) begin
        m_pc = bus.redirect_pc; m_valid = 0;
      end else if (take) begin
        m_inst = mem_word(m_pc[11:0]); m_ipc = m_pc; m_valid = 1; m_pc = m_pc + 32'd4;
      end else if (accept) begin
        m_valid = 0;
      end
    end
  end

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic chkb(input string name, input logic act, input logic exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask

  always begin
    @(negedge clk);
    #2;
    if (cmp_en) begin
      chkb("m_imem_en", bus.imem_en,
           (m_ph == 1) && (!m_valid || bus.inst_ready) && !bus.redirect_valid);
      chk("m_imem_addr", {20'h0, bus.imem_addr}, {20'h0, m_pc[11:0]});
      chkb("m_inst_valid", bus.inst_valid, m_valid);
      chkb("m_fault", bus.fault, m_ph == 2);
      chk("m_inst", bus.inst, m_inst);
      chk("m_inst_pc", bus.inst_pc, m_ipc);
    end
  end

  task automatic pulse_reset();
    @(negedge clk); rst_n = 1'b0;
    @(negedge clk); rst_n = 1'b1;
  endtask

  // Start from IDLE with inst_ready=1; returns just before the cycle presenting inst_pc=8.
  task automatic boot();
    @(negedge clk); bus.start = 1'b1;
    @(negedge clk); bus.start = 1'b0; #3;
    chkb("boot_en", bus.imem_en, 1'b1);
    chk("boot_addr", {20'h0, bus.imem_addr}, 32'h0);
    @(negedge clk); #3;
    chkb("first_valid", bus.inst_valid, 1'b1);
    chk("first_pc", bus.inst_pc, 32'h0);
    chk("first_inst", bus.inst, 32'h1000_0000);
    @(negedge clk); #3;
    chk("second_pc", bus.inst_pc, 32'h4);
    chk("second_inst", bus.inst, 32'h1000_0001);
  endtask

  initial begin
    rst_n = 1'b0;
    bus.start = 1'b0; bus.redirect_valid = 1'b0; bus.redirect_pc = 32'h0; bus.inst_ready = 1'b1;
    @(negedge clk); cmp_en = 1;
    @(negedge clk); #3;
    chkb("rst_valid", bus.inst_valid, 1'b0);
    chkb("rst_fault", bus.fault, 1'b0);
    chkb("rst_en", bus.imem_en, 1'b0);
    chk("rst_inst", bus.inst, 32'h0);
    chk("rst_inst_pc", bus.inst_pc, 32'h0);
    @(negedge clk); rst_n = 1'b1;
    repeat (3) @(negedge clk);
    #3 chkb("idle_no_fetch", bus.imem_en, 1'b0);

    boot();
    @(negedge clk); bus.inst_ready = 1'b0; #3;
    chk("stall_pc", bus.inst_pc, 32'h8);
    chkb("stall_en", bus.imem_en, 1'b0);
    repeat (2) begin
      @(negedge clk); #3;
      chk("stall_hold_pc", bus.inst_pc, 32'h8);
      chk("stall_hold_inst", bus.inst, 32'h1000_0002);
      chkb("stall_hold_en", bus.imem_en, 1'b0);
    end
    @(negedge clk); bus.inst_ready = 1'b1; #3;
    chk("release_pc", bus.inst_pc, 32'h8);
    @(negedge clk); #3;
    chk("after_stall_pc", bus.inst_pc, 32'hC);
    chk("after_stall_inst", bus.inst, 32'h1000_0003);

    pulse_reset();
    boot();
    @(negedge clk); bus.inst_ready = 1'b0; bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h100; #3;
    chk("redir_stall_pc", bus.inst_pc, 32'h8);
    @(negedge clk); bus.redirect_valid = 1'b0; bus.inst_ready = 1'b1; #3;
    chkb("redir_flush", bus.inst_valid, 1'b0);
    chk("redir_addr", {20'h0, bus.imem_addr}, 32'h100);
    @(negedge clk); #3;
    chk("redir_pc0", bus.inst_pc, 32'h100);
    @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h102; #3;
    chk("redir_pc1", bus.inst_pc, 32'h104);
    @(negedge clk); bus.redirect_valid = 1'b0; #3;
    chkb("fault_set", bus.fault, 1'b1);
    chkb("fault_en", bus.imem_en, 1'b0);
    @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'h200; #3;
    chkb("fault_hold", bus.fault, 1'b1);
    @(negedge clk); bus.redirect_valid = 1'b0; #3;
    chkb("fault_clear", bus.fault, 1'b0);
    chkb("fault_exit_en", bus.imem_en, 1'b1);
    @(negedge clk); #3;
    chk("fault_exit_pc", bus.inst_pc, 32'h200);

    @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFC;
    @(negedge clk); bus.redirect_valid = 1'b0; #3;
    chk("win_addr0", {20'h0, bus.imem_addr}, 32'hFFC);
    @(negedge clk); #3;
    chk("win_addr1", {20'h0, bus.imem_addr}, 32'h0);
    chk("win_pc0", bus.inst_pc, 32'hFFC);
    chk("win_inst0", bus.inst, 32'h1000_03FF);
    @(negedge clk); #3;
    chk("win_pc1", bus.inst_pc, 32'h1000);
    chk("win_inst1", bus.inst, 32'h1000_0000);

    @(negedge clk); bus.redirect_valid = 1'b1; bus.redirect_pc = 32'hFFFF_FFFC;
    @(negedge clk); bus.redirect_valid = 1'b0;
    @(negedge clk); #3;
    chk("wrap_pc0", bus.inst_pc, 32'hFFFF_FFFC);
    @(negedge clk); #3;
    chk("wrap_pc1", bus.inst_pc, 32'h0);
    chk("wrap_addr", {20'h0, bus.imem_addr}, 32'h4);

    @(posedge clk); #2; rst_n = 1'b0; #1;
    chkb("async_valid", bus.inst_valid, 1'b0);
    chk("async_addr", {20'h0, bus.imem_addr}, 32'h0);
    chkb("async_en", bus.imem_en, 1'b0);
    @(negedge clk); rst_n = 1'b1;
    repeat (4) begin
      @(negedge clk); #3;
      chkb("post_rst_en", bus.imem_en, 1'b0);
      chkb("post_rst_valid", bus.inst_valid, 1'b0);
    end

    for (int i = 0; i < 3000; i++) begin
      @(negedge clk);
      if (!rst_n) begin
        rst_n = 1'b1;
      end else if ($urandom_range(0, 299) == 0) begin
        rst_n = 1'b0;
      end
      bus.start          = ($urandom_range(0, 15) == 0);
      bus.inst_ready     = ($urandom_range(0, 9) < 7);
      bus.redirect_valid = ($urandom_range(0, 9) == 0);
      case ($urandom_range(0, 7))
        0:       bus.redirect_pc = 32'hFFFF_FFFC;
        1:       bus.redirect_pc = 32'hFFC;
        2:       bus.redirect_pc = {$urandom_range(0, 65535), 2'b00} | 32'($urandom_range(1, 3));
        default: bus.redirect_pc = 32'($urandom_range(0, 1023)) << 2;
      endcase
    end
    @(negedge clk);
    bus.redirect_valid = 1'b0;
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule

// File: doc/bios_fetch.md
BIOS_FETCH -- requirements
Module: bios_fetch

Interface
REQ-001 Parameter RESET_PC, default 32'h0000_0000, is the PC value loaded at reset.
REQ-002 Parameter ADDR_W, default 12, is the byte-address width driven to the BIOS memory port.
REQ-003 clk  input  1  single clock; all state updates on rising edge.
REQ-004 rst_n  input  1  reset; asynchronous assert, active-low.
REQ-005 start  input  1  one-cycle pulse that moves the block from IDLE to RUN.
REQ-006 imem_en  output  1  read enable to the BIOS instruction port.
REQ-007 imem_addr  output  ADDR_W  byte address to the BIOS instruction port; equals pc[ADDR_W-1:0].
REQ-008 imem_rdata  input  32  instruction word, combinationally valid in the same cycle as imem_addr.
REQ-009 redirect_valid  input  1  branch/jump/trap redirect request.
REQ-010 redirect_pc  input  32  redirect target address.
REQ-011 inst_valid  output  1  output holds a valid instruction.
REQ-012 inst_ready  input  1  downstream accepts the instruction.
REQ-013 inst  output  32  fetched instruction word.
REQ-014 inst_pc  output  32  address of inst.
REQ-015 fault  output  1  high while in state FAULT.

Function
REQ-016 The FSM shall have states IDLE, RUN and FAULT.
REQ-017 IDLE->RUN on start=1; start shall be ignored in RUN and FAULT.
REQ-018 RUN->FAULT on redirect_valid=1 with redirect_pc[1:0]!=0.
REQ-019 FAULT->RUN on redirect_valid=1 with redirect_pc[1:0]==0; misaligned redirects in FAULT keep FAULT.
REQ-020 A redirect in IDLE shall load pc only, without changing state; if it is misaligned, the FSM shall enter FAULT.
REQ-021 The output shall be able to accept when inst_valid==0 or inst_ready==1.
REQ-022 imem_en shall equal (state==RUN) && output can accept && !redirect_valid.
REQ-023 When imem_en=1, on the next edge: inst<=imem_rdata, inst_pc<=pc, inst_valid<=1 and pc<=pc+4.
REQ-024 The pc increment shall be 32-bit modulo: 32'hFFFF_FFFC+4 gives 0.
REQ-025 imem_addr shall follow pc[ADDR_W-1:0] and wrap within the BIOS window.
REQ-026 When inst_valid=1 and inst_ready=0 (stall), inst, inst_pc, inst_valid and pc shall hold, with imem_en=0.
REQ-027 When output can accept but imem_en=0 (IDLE or FAULT, no redirect), inst_valid<=0 on the next edge.
REQ-028 Redirect priority is highest: on redirect_valid=1, on the next edge pc<=redirect_pc and inst_valid<=0, regardless of inst_ready or a stall.
REQ-029 Redirect flushes any held instruction; no instruction fetched before the redirect shall appear after it.
REQ-030 With continuous inst_ready=1 and no redirect, throughput shall be one instruction per cycle.
REQ-031 Latency from pc presentation to inst_valid shall be 1 cycle.
REQ-032 inst and inst_pc shall not change while inst_valid=1 and inst_ready=0.
REQ-033 fault shall be a registered output equal to (state==FAULT).

Reset
REQ-034 rst_n=0 shall immediately force: state IDLE, pc=RESET_PC, inst_valid=0, inst=0, inst_pc=0, fault=0.
REQ-035 imem_en shall be 0 during reset.
REQ-036 Reset asserted mid-stall or mid-redirect shall discard all in-flight state.
REQ-037 After rst_n deassertion, the block shall remain in IDLE until start.

Verification
REQ-038 Reset, then start, memory word at i equal to 32'h1000_0000+i, inst_ready=1 -> inst_valid rises 1 cycle after start+1; inst_pc sequence 0,4,8,... and inst 32'h1000_0000, 32'h1000_0001, ... one per cycle.
REQ-039 Hold inst_ready=0 for 3 cycles while inst_pc=8 -> inst=mem[2] and inst_pc=8 stable, imem_en=0; after release, the next inst_pc is 12 with no gap or duplicate.
REQ-040 During a stall at inst_pc=8, redirect_pc=32'h100 -> next cycle inst_valid=0; following cycle inst_pc=32'h100, then 32'h104.
REQ-041 redirect_pc=32'h102 -> fault=1 and imem_en=0; then redirect_pc=32'h200 -> fault=0 and the next inst_pc is 32'h200.
REQ-042 Redirect to 32'hFFC with ADDR_W=12 -> imem_addr sequence 12'hFFC, 12'h000; inst_pc sequence 32'hFFC, 32'h1000.
REQ-043 Assert rst_n=0 asynchronously mid-stream between edges -> inst_valid=0 and pc=RESET_PC immediately; no fetch until the next start pulse.
